sine_voice_scheduler: RTL

- Time-multiplexes one shared sine lookup-table tone generator across NUM_VOICES voices.
- Each voice has its own frequency word, enable bit and phase accumulator.
- On every sample tick, the block steps through the voices in order, presents each accumulator to the shared LUT, mixes the returned values and emits one summed sample.
- Sits between the synth control/config logic and the audio output path; the LUT itself is instantiated outside this block.

---
 rtl/sine_voice_scheduler_pkg.sv | 15 +
 rtl/sine_voice_scheduler_voice_param_bank.sv | 57 +++++
 rtl/sine_voice_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sine_voice_scheduler_pkg.sv
// Shared types and helpers for the sine voice scheduler.
// Holds the sequencer state encoding and the mix-width derivation.
package sine_voice_scheduler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Sum of NUM_VOICES signed OUTPUT_BITS values needs log2(N) guard bits.
    function automatic int mix_width(input int out_bits, input int voices);
        return out_bits + $clog2(voices);
    endfunction

endpackage

// File: rtl/sine_voice_scheduler_voice_param_bank.sv
// Per-voice frequency, enable and phase accumulator storage.
// Config writes and sequencer accumulate steps share one register set.
module voice_param_bank
    import sine_voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES       = 4,
    parameter int ACCUMULATOR_BITS = 24,
    parameter int VOICE_BITS       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [VOICE_BITS-1:0]       cfg_voice,
    input  logic [ACCUMULATOR_BITS-1:0] cfg_freq,
    input  logic                        cfg_enable,
    input  logic                        step,
    input  logic [VOICE_BITS-1:0]       step_voice,
    input  logic [VOICE_BITS-1:0]       next_voice,
    output logic                        cur_enable,
    output logic [ACCUMULATOR_BITS-1:0] next_accumulator
);

    logic [ACCUMULATOR_BITS-1:0] freq [NUM_VOICES];
    logic [ACCUMULATOR_BITS-1:0] acc  [NUM_VOICES];
    logic                        en   [NUM_VOICES];

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        logic wr_hit;
        logic step_hit;

        assign wr_hit   = cfg_we && (cfg_voice == VOICE_BITS'(i));
        assign step_hit = step && (step_voice == VOICE_BITS'(i));

        // Config write wins over a same-edge accumulate; the step uses old freq/en.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                freq[i] <= '0;
                en[i]   <= 1'b0;
                acc[i]  <= '0;
            end else begin
                if (wr_hit) begin
                    freq[i] <= cfg_freq;
                    en[i]   <= cfg_enable;
                end
                if (wr_hit && !cfg_enable) begin
                    acc[i] <= '0;
                end else if (step_hit && en[i]) begin
                    acc[i] <= acc[i] + freq[i];
                end
            end
        end
    end

    assign cur_enable       = en[step_voice];
    assign next_accumulator = acc[next_voice];

endmodule

// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one external sine LUT across NUM_VOICES voices.
// Each sample tick walks the voices in order and emits their summed output.
module sine_voice_scheduler
    import sine_voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES       = 4,
    parameter int ACCUMULATOR_BITS = 24,
    parameter int OUTPUT_BITS      = 16,
    localparam int VOICE_BITS      = $clog2(NUM_VOICES),
    localparam int MIX_BITS        = mix_width(OUTPUT_BITS, NUM_VOICES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_tick,
    input  logic                        cfg_we,
    input  logic [VOICE_BITS-1:0]       cfg_voice,
    input  logic [ACCUMULATOR_BITS-1:0] cfg_freq,
    input  logic                        cfg_enable,
    output logic [ACCUMULATOR_BITS-1:0] lut_accumulator,
    input  logic [OUTPUT_BITS-1:0]      lut_dout,
    output logic [MIX_BITS-1:0]         sample_out,
    output logic                        sample_valid,
    output logic                        busy,
    output logic                        overrun
);

    state_t                      state;
    state_t                      state_next;
    logic [VOICE_BITS-1:0]       idx;
    logic [VOICE_BITS-1:0]       next_voice;
    logic [MIX_BITS-1:0]         sum;
    logic [MIX_BITS-1:0]         contribution;
    logic [OUTPUT_BITS-1:0]      signed_dout;
    logic [ACCUMULATOR_BITS-1:0] next_accumulator;
    logic                        cur_enable;
    logic                        accept;
    logic                        step;
    logic                        last;
    logic                        finish;
    logic                        drop;

    voice_param_bank #(
        .NUM_VOICES      (NUM_VOICES),
        .ACCUMULATOR_BITS(ACCUMULATOR_BITS),
        .VOICE_BITS      (VOICE_BITS)
    ) u_bank (
        .clk             (clk),
        .rst             (rst),
        .cfg_we          (cfg_we),
        .cfg_voice       (cfg_voice),
        .cfg_freq        (cfg_freq),
        .cfg_enable      (cfg_enable),
        .step            (step),
        .step_voice      (idx),
        .next_voice      (next_voice),
        .cur_enable      (cur_enable),
        .next_accumulator(next_accumulator)
    );

    assign last = (idx == VOICE_BITS'(NUM_VOICES - 1));

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a tick starts a run, the last voice ends it.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (sample_tick) state_next = RUN;
            RUN:  if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        accept     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        drop       = 1'b0;
        next_voice = '0;
        unique case (state)
            IDLE: begin
                accept = sample_tick;
            end
            RUN: begin
                step       = 1'b1;
                finish     = last;
                drop       = sample_tick;
                next_voice = idx + 1'b1;
            end
            default: ;
        endcase
    end

    // Offset-binary LUT word to signed, widened to the mix width.
    always_comb begin
        signed_dout  = {~lut_dout[OUTPUT_BITS-1], lut_dout[OUTPUT_BITS-2:0]};
        contribution = '0;
        if (cur_enable) begin
            contribution = {{VOICE_BITS{signed_dout[OUTPUT_BITS-1]}}, signed_dout};
        end
    end

    // Datapath: voice index, LUT address, running sum and output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx             <= '0;
            sum             <= '0;
            lut_accumulator <= '0;
            sample_out      <= '0;
            sample_valid    <= 1'b0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            sample_valid <= finish;
            overrun      <= drop;
            if (accept) begin
                idx             <= '0;
                sum             <= '0;
                lut_accumulator <= next_accumulator;
                busy            <= 1'b1;
            end
            if (step) begin
                sum <= sum + contribution;
                if (!last) begin
                    idx             <= idx + 1'b1;
                    lut_accumulator <= next_accumulator;
                end else begin
                    sample_out <= sum + contribution;
                    busy       <= 1'b0;
                end
            end
        end
    end

endmodule
